// File: rtl/wb_seq_down_bridge.sv
// Wishbone width-down bridge: one wide classic access is replayed as one narrow beat per active lane group.
// Optional beat watchdog enabled by defining WB_SEQ_DOWN_BRIDGE_TIMEOUT_EN.
module wb_seq_down_bridge #(
    parameter int AW      = 32,
    parameter int SDW     = 128,
    parameter int MDW     = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [AW-1:0]      i_s_wb_adr,
    input  logic [SDW/8-1:0]   i_s_wb_sel,
    input  logic               i_s_wb_we,
    input  logic [SDW-1:0]     i_s_wb_dat,
    output logic [SDW-1:0]     o_s_wb_dat,
    input  logic               i_s_wb_cyc,
    input  logic               i_s_wb_stb,
    output logic               o_s_wb_ack,
    output logic               o_s_wb_err,
    output logic [AW-1:0]      o_m_wb_adr,
    output logic [MDW/8-1:0]   o_m_wb_sel,
    output logic               o_m_wb_we,
    output logic [MDW-1:0]     o_m_wb_dat,
    input  logic [MDW-1:0]     i_m_wb_dat,
    output logic               o_m_wb_cyc,
    output logic               o_m_wb_stb,
    input  logic               i_m_wb_ack,
    input  logic               i_m_wb_err
);
    localparam int SSW  = SDW / 8;
    localparam int MSW  = MDW / 8;
    localparam int NB   = SDW / MDW;
    localparam int LSDW = $clog2(SSW);
    localparam int LMDW = $clog2(MSW);
    localparam int KW   = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BEAT = 2'd1, S_RESP = 2'd2} state_e;

    state_e               state_q, state_d;
    logic [AW-LSDW-1:0]   adr_q, adr_d;
    logic [SSW-1:0]       sel_q, sel_d;
    logic                 we_q, we_d;
    logic [SDW-1:0]       dat_q, dat_d;
    logic [KW-1:0]        k_q, k_d;
    logic [SDW-1:0]       rdat_q, rdat_d;
    logic                 err_q, err_d;
    logic                 drop_q, drop_d;
    logic                 drop_nxt_s;
    logic [KW:0]          lane_s;
    logic                 timeout_s;
    logic                 beat_s;
    logic [AW-1:0]        beat_adr_s;
    logic                 unused_s;

    // Returns {found, index} of the lowest lane >= from that has any byte select set.
    function automatic logic [KW:0] find_lane(input logic [SSW-1:0] sel, input int from);
        logic [KW:0] res;
        res = '0;
        for (int j = NB - 1; j >= 0; j--) begin
            if ((j >= from) && (sel[j*MSW +: MSW] != '0)) begin
                res = {1'b1, KW'(j)};
            end
        end
        return res;
    endfunction

`ifdef WB_SEQ_DOWN_BRIDGE_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] wd_q, wd_d;

    // Watchdog: counts unterminated beat cycles, fires on the cycle that would reach TIMEOUT.
    always_comb begin
        wd_d      = '0;
        timeout_s = 1'b0;
        if ((state_q == S_BEAT) && !i_m_wb_ack && !i_m_wb_err) begin
            if (wd_q == WDW'(TIMEOUT - 1)) begin
                timeout_s = 1'b1;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end else begin
            wd_d = '0;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    assign unused_s = ^{i_s_wb_adr[LSDW-1:0], 32'(TIMEOUT)};

    // Next-state logic: capture, lane sequencing, read assembly and termination handling.
    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        sel_d      = sel_q;
        we_d       = we_q;
        dat_d      = dat_q;
        k_d        = k_q;
        rdat_d     = rdat_q;
        err_d      = err_q;
        drop_d     = drop_q;
        lane_s     = '0;
        drop_nxt_s = drop_q | ~i_s_wb_cyc;
        case (state_q)
            S_IDLE: begin
                if (i_s_wb_cyc && i_s_wb_stb) begin
                    adr_d  = i_s_wb_adr[AW-1:LSDW];
                    sel_d  = i_s_wb_sel;
                    we_d   = i_s_wb_we;
                    dat_d  = i_s_wb_dat;
                    rdat_d = '0;
                    err_d  = 1'b0;
                    drop_d = 1'b0;
                    lane_s = find_lane(i_s_wb_sel, 0);
                    k_d    = lane_s[KW-1:0];
                    state_d = lane_s[KW] ? S_BEAT : S_RESP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BEAT: begin
                // An error (external or watchdog) wins over a simultaneous ack.
                if (i_m_wb_err || timeout_s) begin
                    err_d   = ~drop_nxt_s;
                    state_d = drop_nxt_s ? S_IDLE : S_RESP;
                end else if (i_m_wb_ack) begin
                    if (!we_q) begin
                        rdat_d[k_q*MDW +: MDW] = i_m_wb_dat;
                    end else begin
                        rdat_d = rdat_q;
                    end
                    lane_s = find_lane(sel_q, int'(k_q) + 1);
                    if (drop_nxt_s) begin
                        state_d = S_IDLE;
                    end else if (lane_s[KW]) begin
                        k_d = lane_s[KW-1:0];
                    end else begin
                        state_d = S_RESP;
                    end
                end else begin
                    drop_d = drop_nxt_s;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and captured-request registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            adr_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            dat_q   <= '0;
            k_q     <= '0;
            rdat_q  <= '0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            dat_q   <= dat_d;
            k_q     <= k_d;
            rdat_q  <= rdat_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
        end
    end

    assign beat_s     = (state_q == S_BEAT);
    assign beat_adr_s = {adr_q, {LSDW{1'b0}}} | (AW'(k_q) << LMDW);

    assign o_m_wb_cyc = beat_s;
    assign o_m_wb_stb = beat_s;
    assign o_m_wb_adr = beat_s ? beat_adr_s : '0;
    assign o_m_wb_sel = beat_s ? sel_q[k_q*MSW +: MSW] : '0;
    assign o_m_wb_dat = beat_s ? dat_q[k_q*MDW +: MDW] : '0;
    assign o_m_wb_we  = beat_s & we_q;
    assign o_s_wb_ack = (state_q == S_RESP) & ~err_q;
    assign o_s_wb_err = (state_q == S_RESP) & err_q;
    assign o_s_wb_dat = rdat_q;
endmodule

// File: tb/tb_wb_seq_down_bridge.sv
// Directed self-checking bench for wb_seq_down_bridge (128-bit slave, 32-bit master, TIMEOUT=8).
module tb_wb_seq_down_bridge;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  s_adr = '0;
    logic [15:0]  s_sel = '0;
    logic         s_we = 1'b0;
    logic [127:0] s_dat = '0;
    logic         s_cyc = 1'b0;
    logic         s_stb = 1'b0;
    logic [127:0] s_rdat;
    logic         s_ack, s_err;
    logic [31:0]  m_adr;
    logic [3:0]   m_sel;
    logic         m_we;
    logic [31:0]  m_wdat;
    logic [31:0]  m_rdat;
    logic         m_cyc, m_stb;
    logic         m_ack, m_err;

    int checks = 0;
    int failures = 0;
    int cyc_n = 0, beat_n = 0, wcnt = 0;
    int ack_cnt = 0, err_cnt = 0, stb_cnt = 0;
    int m_wait = 0, err_beat = -1;
    bit never = 1'b0;
    int t0 = 0;
    logic [31:0] rd_mem [4];
    logic [31:0] lg_adr [64];
    logic [3:0]  lg_sel [64];
    logic [31:0] lg_dat [64];
    logic        lg_we  [64];

    always #5 clk = ~clk;

    wb_seq_down_bridge #(.AW(32), .SDW(128), .MDW(32), .TIMEOUT(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_s_wb_adr(s_adr), .i_s_wb_sel(s_sel), .i_s_wb_we(s_we), .i_s_wb_dat(s_dat),
        .o_s_wb_dat(s_rdat), .i_s_wb_cyc(s_cyc), .i_s_wb_stb(s_stb),
        .o_s_wb_ack(s_ack), .o_s_wb_err(s_err),
        .o_m_wb_adr(m_adr), .o_m_wb_sel(m_sel), .o_m_wb_we(m_we), .o_m_wb_dat(m_wdat),
        .i_m_wb_dat(m_rdat), .o_m_wb_cyc(m_cyc), .o_m_wb_stb(m_stb),
        .i_m_wb_ack(m_ack), .i_m_wb_err(m_err)
    );

    // Narrow slave model: configurable wait states, error on a chosen beat, or never terminate.
    always_comb begin
        m_ack = 1'b0;
        m_err = 1'b0;
        if (m_stb && !never && (wcnt >= m_wait)) begin
            if (beat_n == err_beat) m_err = 1'b1;
            else m_ack = 1'b1;
        end
        m_rdat = rd_mem[m_adr[3:2]];
    end

    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        if (m_stb && (m_ack || m_err)) begin
            if (beat_n < 64) begin
                lg_adr[beat_n] <= m_adr;
                lg_sel[beat_n] <= m_sel;
                lg_dat[beat_n] <= m_wdat;
                lg_we[beat_n]  <= m_we;
            end
            beat_n <= beat_n + 1;
            wcnt   <= 0;
        end else if (m_stb) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    always @(negedge clk) begin
        ack_cnt <= ack_cnt + int'(s_ack);
        err_cnt <= err_cnt + int'(s_err);
        stb_cnt <= stb_cnt + int'(m_stb);
    end

    task automatic issue(input logic [31:0] adr, input logic [15:0] sel, input logic we, input logic [127:0] dat);
        @(posedge clk);
        #1;
        s_adr = adr; s_sel = sel; s_we = we; s_dat = dat;
        s_cyc = 1'b1; s_stb = 1'b1;
        t0 = cyc_n;
    endtask

    task automatic wait_resp(output int rel, output logic [127:0] sd, output bit ga, output bit ge, output bit ok);
        ok = 1'b0; ga = 1'b0; ge = 1'b0; rel = -1; sd = '0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (s_ack || s_err) begin
                ok = 1'b1; ga = s_ack; ge = s_err; rel = cyc_n - t0; sd = s_rdat;
            end
        end
        s_cyc = 1'b0; s_stb = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({m_cyc, m_stb, m_adr, m_sel, m_we, m_wdat, s_ack, s_err, s_rdat} !== '0) begin
            failures++; $display("FAIL reset_outputs got=%h exp=0", {m_cyc, m_stb, m_adr, s_ack, s_err, s_rdat});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({m_stb, s_ack, s_err} !== 3'b000) begin
            failures++; $display("FAIL reset_idle got=%b exp=000", {m_stb, s_ack, s_err});
        end
    endtask

    task automatic test_read_full;
        int rel, b0, a0; logic [127:0] sd; bit ga, ge, ok;
        b0 = beat_n; a0 = ack_cnt;
        issue(32'h100, 16'hFFFF, 1'b0, '0);
        wait_resp(rel, sd, ga, ge, ok);
        repeat (2) @(negedge clk);
        checks++;
        if (!ok || !ga || rel != 5) begin
            failures++; $display("FAIL rd_full_ack got ok=%0b ack=%0b cyc=%0d exp ack at 5", ok, ga, rel);
        end
        checks++;
        if (sd !== 128'h44444444_33333333_22222222_11111111) begin
            failures++; $display("FAIL rd_full_data got=%h exp=44444444333333332222222211111111", sd);
        end
        checks++;
        if (beat_n - b0 != 4 || ack_cnt - a0 != 1) begin
            failures++; $display("FAIL rd_full_counts got beats=%0d acks=%0d exp 4/1", beat_n - b0, ack_cnt - a0);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (lg_adr[b0+i] !== 32'h100 + 32'(4*i) || lg_sel[b0+i] !== 4'hF || lg_we[b0+i] !== 1'b0) begin
                failures++; $display("FAIL rd_full_beat%0d got adr=%h sel=%h we=%b exp adr=%h sel=f we=0",
                                     i, lg_adr[b0+i], lg_sel[b0+i], lg_we[b0+i], 32'h100 + 32'(4*i));
            end
        end
    endtask

    task automatic test_write_lane2;
        int rel, b0; logic [127:0] sd; bit ga, ge, ok;
        b0 = beat_n;
        issue(32'h200, 16'h0F00, 1'b1, 128'hAAAAAAAA_DEADBEEF_CCCCCCCC_BBBBBBBB);
        wait_resp(rel, sd, ga, ge, ok);
        @(negedge clk);
        checks++;
        if (!ok || !ga || rel != 2) begin
            failures++; $display("FAIL wr_ack got ok=%0b ack=%0b cyc=%0d exp ack at 2", ok, ga, rel);
        end
        checks++;
        if (beat_n - b0 != 1 || lg_adr[b0] !== 32'h208 || lg_sel[b0] !== 4'hF ||
            lg_dat[b0] !== 32'hDEADBEEF || lg_we[b0] !== 1'b1) begin
            failures++; $display("FAIL wr_beat got n=%0d adr=%h sel=%h dat=%h we=%b exp 1/208/f/deadbeef/1",
                                 beat_n - b0, lg_adr[b0], lg_sel[b0], lg_dat[b0], lg_we[b0]);
        end
        checks++;
        if (sd !== '0) begin
            failures++; $display("FAIL wr_rdata got=%h exp=0", sd);
        end
    endtask

    task automatic test_partial_read;
        int rel, b0; logic [127:0] sd; bit ga, ge, ok;
        b0 = beat_n;
        issue(32'h340, 16'h3060, 1'b0, '0);
        wait_resp(rel, sd, ga, ge, ok);
        @(negedge clk);
        checks++;
        if (!ok || !ga || rel != 3) begin
            failures++; $display("FAIL part_ack got ok=%0b ack=%0b cyc=%0d exp ack at 3", ok, ga, rel);
        end
        checks++;
        if (beat_n - b0 != 2 || lg_adr[b0] !== 32'h344 || lg_sel[b0] !== 4'h6 ||
            lg_adr[b0+1] !== 32'h34C || lg_sel[b0+1] !== 4'h3) begin
            failures++; $display("FAIL part_beats got n=%0d %h/%h %h/%h exp 2 344/6 34c/3",
                                 beat_n - b0, lg_adr[b0], lg_sel[b0], lg_adr[b0+1], lg_sel[b0+1]);
        end
        checks++;
        if (sd !== 128'h44444444_00000000_22222222_00000000) begin
            failures++; $display("FAIL part_data got=%h exp=44444444000000002222222200000000", sd);
        end
    endtask

    task automatic test_error;
        int rel, b0, a0, e0; logic [127:0] sd; bit ga, ge, ok;
        b0 = beat_n; a0 = ack_cnt; e0 = err_cnt;
        err_beat = beat_n + 2;
        issue(32'h100, 16'hFFFF, 1'b0, '0);
        wait_resp(rel, sd, ga, ge, ok);
        repeat (2) @(negedge clk);
        err_beat = -1;
        checks++;
        if (!ok || !ge || ga || rel != 4) begin
            failures++; $display("FAIL err_resp got ok=%0b err=%0b ack=%0b cyc=%0d exp err at 4", ok, ge, ga, rel);
        end
        checks++;
        if (beat_n - b0 != 3 || err_cnt - e0 != 1 || ack_cnt - a0 != 0) begin
            failures++; $display("FAIL err_counts got beats=%0d errs=%0d acks=%0d exp 3/1/0",
                                 beat_n - b0, err_cnt - e0, ack_cnt - a0);
        end
    endtask

    task automatic test_back_to_back;
        int r1, r2, n, s0;
        r1 = -1; r2 = -1; n = 0; s0 = stb_cnt;
        issue(32'h400, 16'h0000, 1'b0, '0);
        for (int i = 0; i < 20 && n < 2; i++) begin
            @(negedge clk);
            if (s_ack) begin
                if (n == 0) r1 = cyc_n - t0;
                else r2 = cyc_n - t0;
                n++;
            end
        end
        s_cyc = 1'b0; s_stb = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (r1 != 1 || r2 != 3) begin
            failures++; $display("FAIL b2b_acks got first=%0d second=%0d exp 1/3", r1, r2);
        end
        checks++;
        if (stb_cnt - s0 != 0) begin
            failures++; $display("FAIL b2b_nostb got=%0d exp=0", stb_cnt - s0);
        end
    endtask

    task automatic test_slave_drop;
        int b0, a0, e0, s0;
        b0 = beat_n; a0 = ack_cnt; e0 = err_cnt; s0 = stb_cnt;
        m_wait = 2;
        issue(32'h500, 16'hFFFF, 1'b0, '0);
        repeat (2) @(negedge clk);
        s_cyc = 1'b0; s_stb = 1'b0;
        repeat (10) @(negedge clk);
        m_wait = 0;
        checks++;
        if (beat_n - b0 != 1 || stb_cnt - s0 != 3) begin
            failures++; $display("FAIL drop_beats got beats=%0d stb=%0d exp 1/3", beat_n - b0, stb_cnt - s0);
        end
        checks++;
        if (ack_cnt - a0 != 0 || err_cnt - e0 != 0) begin
            failures++; $display("FAIL drop_noresp got acks=%0d errs=%0d exp 0/0", ack_cnt - a0, err_cnt - e0);
        end
    endtask

    task automatic test_reset_midbeat;
        int b0, a0, e0;
        b0 = beat_n; a0 = ack_cnt; e0 = err_cnt;
        m_wait = 3;
        issue(32'h600, 16'hFFFF, 1'b0, '0);
        repeat (3) @(negedge clk);
        checks++;
        if (m_stb !== 1'b1) begin
            failures++; $display("FAIL rstmid_busy got stb=%b exp=1", m_stb);
        end
        rst_n = 1'b0; s_cyc = 1'b0; s_stb = 1'b0;
        #1;
        checks++;
        if ({m_cyc, m_stb, m_adr, m_sel, m_we, m_wdat, s_ack, s_err, s_rdat} !== '0) begin
            failures++; $display("FAIL rstmid_outputs got=%h exp=0", {m_cyc, m_stb, m_adr, m_sel, m_we, m_wdat});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        m_wait = 0;
        checks++;
        if (m_stb !== 1'b0 || beat_n - b0 != 0 || ack_cnt - a0 != 0 || err_cnt - e0 != 0) begin
            failures++; $display("FAIL rstmid_after got stb=%b beats=%0d acks=%0d errs=%0d exp 0/0/0/0",
                                 m_stb, beat_n - b0, ack_cnt - a0, err_cnt - e0);
        end
    endtask

`ifdef WB_SEQ_DOWN_BRIDGE_TIMEOUT_EN
    task automatic test_timeout;
        int rel, s0; logic [127:0] sd; bit ga, ge, ok;
        s0 = stb_cnt;
        never = 1'b1;
        issue(32'h700, 16'hFFFF, 1'b0, '0);
        wait_resp(rel, sd, ga, ge, ok);
        never = 1'b0;
        @(negedge clk);
        checks++;
        if (!ok || !ge || ga || rel != 9) begin
            failures++; $display("FAIL timeout_err got ok=%0b err=%0b ack=%0b cyc=%0d exp err at 9", ok, ge, ga, rel);
        end
        checks++;
        if (stb_cnt - s0 != 8 || m_stb !== 1'b0) begin
            failures++; $display("FAIL timeout_stb got cycles=%0d stb=%b exp 8/0", stb_cnt - s0, m_stb);
        end
    endtask
`else
    task automatic test_no_timeout;
        int rel, b0, a0, e0; logic [127:0] sd; bit ga, ge, ok;
        b0 = beat_n; a0 = ack_cnt; e0 = err_cnt;
        never = 1'b1;
        issue(32'h700, 16'hFFFF, 1'b0, '0);
        repeat (120) @(negedge clk);
        checks++;
        if (m_stb !== 1'b1 || beat_n - b0 != 0 || ack_cnt - a0 != 0 || err_cnt - e0 != 0) begin
            failures++; $display("FAIL nowd_hold got stb=%b beats=%0d acks=%0d errs=%0d exp 1/0/0/0",
                                 m_stb, beat_n - b0, ack_cnt - a0, err_cnt - e0);
        end
        never = 1'b0;
        wait_resp(rel, sd, ga, ge, ok);
        @(negedge clk);
        checks++;
        if (!ok || !ga || sd !== 128'h44444444_33333333_22222222_11111111) begin
            failures++; $display("FAIL nowd_finish got ok=%0b ack=%0b data=%h exp ack with full data", ok, ga, sd);
        end
    endtask
`endif

    initial begin
        rd_mem[0] = 32'h11111111;
        rd_mem[1] = 32'h22222222;
        rd_mem[2] = 32'h33333333;
        rd_mem[3] = 32'h44444444;
        test_reset();
        test_read_full();
        test_write_lane2();
        test_partial_read();
        test_error();
        test_back_to_back();
        test_slave_drop();
        test_reset_midbeat();
`ifdef WB_SEQ_DOWN_BRIDGE_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
